// File: rtl/hex_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_display_ctrl
//  Purpose  : Registered multi-digit seven-segment driver with a load-latched
//             shadow word, leading-zero suppression, per-digit blinking from a
//             free-running divider and a global blank.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic                    enable,
  output logic [7*NUM_DIGITS-1:0] segments_out,
  output logic                    blink_phase
);

  localparam int             CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX    = CW'(BLINK_DIV - 1);
  localparam logic [6:0]     BLANK_CODE = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   lz_supp;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'b1000000;  4'h1: r = 7'b1111001;
      4'h2: r = 7'b0100100;  4'h3: r = 7'b0110000;
      4'h4: r = 7'b0011001;  4'h5: r = 7'b0010010;
      4'h6: r = 7'b0000010;  4'h7: r = 7'b1111000;
      4'h8: r = 7'b0000000;  4'h9: r = 7'b0011000;
      4'hA: r = 7'b0001000;  4'hB: r = 7'b0000011;
      4'hC: r = 7'b1000110;  4'hD: r = 7'b0100001;
      4'hE: r = 7'b0000110;  default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so an all-zero word still displays "0".
  assign lz_supp[0] = 1'b0;
  generate
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
      assign lz_supp[k] = lz_en && (value_q[4*NUM_DIGITS-1:4*k] == '0);
    end
  endgenerate

  // Blink divider next state: wrap at the terminal count and flip the phase.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Per-digit glyph with blank priority enable > blink-off > leading zero.
  always_comb begin
    logic [6:0] code;
    seg_d = '0;
    code  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      code = decode(value_q[4*k +: 4]);
      if (!enable || (mask_q[k] && phase_q) || lz_supp[k])
        code = 7'h7F;
      seg_d[7*k +: 7] = (ACTIVE_LOW != 0) ? code : ~code;
    end
  end

  // Shadow registers, divider and output register share one clocked block.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      if (load) begin
        value_q <= value_in;
        mask_q  <= blink_mask_in;
      end
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign segments_out = seg_q;
  assign blink_phase  = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_display_ctrl
//  Purpose  : Scoreboard bench for hex_display_ctrl; two instances (active-low
//             slow blink, active-high blink every cycle) share the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0]  mask_in = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic        enable = 1'b1;
  logic [27:0] seg0, seg1;
  logic        ph0, ph1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(4), .ACTIVE_LOW(1)) u_dut0 (
    .clk(clk), .reset(reset), .value_in(value_in), .blink_mask_in(mask_in),
    .load(load), .lz_en(lz_en), .enable(enable),
    .segments_out(seg0), .blink_phase(ph0));

  hex_display_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(1), .ACTIVE_LOW(0)) u_dut1 (
    .clk(clk), .reset(reset), .value_in(value_in), .blink_mask_in(mask_in),
    .load(load), .lz_en(lz_en), .enable(enable),
    .segments_out(seg1), .blink_phase(ph1));

  // Glyph table for digits 0..F, active-low.
  logic [6:0] DEC [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed { logic [27:0] seg; logic ph; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: shadow word/mask and edges since last reset.
  logic [15:0] mv [2];
  logic [3:0]  mm [2];
  int          medges [2];
  int          DIVS [2] = '{4, 1};
  bit          ALS  [2] = '{1'b1, 1'b0};

  function automatic logic phase_of(input int edges, input int div);
    return ((edges / div) % 2) == 1;
  endfunction

  // Display as a human reads it: scan from the top digit, blanking zeros
  // until the first non-zero one, digit 0 always visible.
  function automatic logic [27:0] display(input logic [15:0] v, input logic [3:0] mk,
                                          input logic ph, input logic lz,
                                          input logic en, input bit al);
    logic [27:0] r;
    logic        seen;
    logic [3:0]  nib;
    logic [6:0]  c;
    logic        blank;
    r = '0;
    seen = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      nib = v[4*k +: 4];
      if (nib != 4'h0) seen = 1'b1;
      blank = !en || (mk[k] && ph) || (lz && !seen && k != 0);
      c = blank ? 7'h7F : DEC[nib];
      if (!al) c = ~c;
      r[7*k +: 7] = c;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at each edge predict what the outputs become after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          mv[d] = '0;
          mm[d] = '0;
          medges[d] = 0;
          e.seg = ALS[d] ? {4{7'h7F}} : 28'h0;
          e.ph  = 1'b0;
        end else begin
          e.seg = display(mv[d], mm[d], phase_of(medges[d], DIVS[d]),
                          lz_en, enable, ALS[d]);
          if (load) begin
            mv[d] = value_in;
            mm[d] = mask_in;
          end
          medges[d]++;
          e.ph = phase_of(medges[d], DIVS[d]);
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs shortly after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() == 0) chk("sb0_empty", 32'd0, 32'd1);
      else begin
        e = q0.pop_front();
        chk("dut0_seg", {4'h0, seg0}, {4'h0, e.seg});
        chk("dut0_phase", {31'h0, ph0}, {31'h0, e.ph});
      end
      if (q1.size() == 0) chk("sb1_empty", 32'd0, 32'd1);
      else begin
        e = q1.pop_front();
        chk("dut1_seg", {4'h0, seg1}, {4'h0, e.seg});
        chk("dut1_phase", {31'h0, ph1}, {31'h0, e.ph});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    value_in = v;
    mask_in  = m;
    load     = 1'b1;
    cyc();
    load     = 1'b0;
    cyc();
  endtask

  initial begin
    logic [3:0] nib;
    logic [15:0] rv;
    int i;

    // Reset, then an all-zero display one cycle after release.
    repeat (3) cyc();
    chk("reset_blank", {4'h0, seg0}, {4'h0, {4{7'h7F}}});
    reset = 1'b0;
    lz_en = 1'b0;
    enable = 1'b1;
    cyc();
    chk("release_zeros", {4'h0, seg0}, {4'h0, {4{7'b1000000}}});

    // Two-cycle load latency.
    do_load(16'h12AF, 4'b0000);
    chk("load_12AF", {4'h0, seg0},
        {4'h0, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

    // Leading-zero suppression.
    lz_en = 1'b1;
    do_load(16'h0040, 4'b0000);
    chk("lz_0040", {4'h0, seg0}, {4'h0, 7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
    do_load(16'h0000, 4'b0000);
    chk("lz_0000", {4'h0, seg0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    lz_en = 1'b0;
    cyc();
    chk("lz_off", {4'h0, seg0}, {4'h0, {4{7'b1000000}}});

    // Blink on digits 0 and 2.
    do_load(16'h8888, 4'b0101);
    repeat (20) cyc();

    // Global blank during blink-on phase.
    for (i = 0; i < 10 && ph0 !== 1'b0; i++) cyc();
    chk("wait_phase0", {31'h0, ph0}, 32'd0);
    enable = 1'b0;
    cyc();
    chk("enable_blank", {4'h0, seg0}, {4'h0, {4{7'h7F}}});
    enable = 1'b1;

    // Reset while the blink phase is off.
    for (i = 0; i < 10 && ph0 !== 1'b1; i++) cyc();
    chk("wait_phase1", {31'h0, ph0}, 32'd1);
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    repeat (10) cyc();

    // Active-high instance: digit 0 blinks every cycle, others blank.
    lz_en = 1'b1;
    do_load(16'h0007, 4'b0001);
    repeat (8) cyc();
    chk("pol_blank_hi", {11'h0, seg1[27:7]}, 32'd0);

    // Randomized traffic with zero-biased nibbles.
    lz_en = 1'b0;
    repeat (400) begin
      rv = '0;
      for (int k = 0; k < 4; k++) begin
        nib = 4'($urandom_range(15, 0));
        if ($urandom_range(1, 0) == 0) nib = 4'h0;
        rv[4*k +: 4] = nib;
      end
      value_in = rv;
      mask_in  = 4'($urandom_range(15, 0));
      load     = ($urandom_range(3, 0) == 0);
      if ($urandom_range(7, 0) == 0) lz_en = ~lz_en;
      enable   = ($urandom_range(15, 0) != 0);
      reset    = ($urandom_range(63, 0) == 0);
      cyc();
    end
    reset = 1'b0;
    load = 1'b0;
    enable = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller for DE1-SoC-class boards. It replaces per-digit combinational hex decoding with a registered driver. The driver latches a display word on a load strobe and decodes all digits. It also provides optional leading-zero suppression, per-digit blinking from an internal divider, and a global blank. It sits between datapath or status logic and the HEXn pins of the board top level.

Parameters:
- NUM_DIGITS, 6: number of digits driven; valid range 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period; must be >= 1. At 50 MHz the default gives 1 Hz on/off.
- ACTIVE_LOW, 1: 1 means segment lit = 0, blank = 7'h7F. 0 means all segment outputs are inverted (lit = 1, blank = 7'h00).

Ports:
- clk, input, 1: system clock (CLOCK_50 at top level).
- reset, input, 1: synchronous, active-high reset.
- value_in, input, 4*NUM_DIGITS: hex nibbles; bits [3:0] are digit 0 (rightmost).
- blink_mask_in, input, NUM_DIGITS: per-digit blink enable, latched together with value_in.
- load, input, 1: single-cycle strobe; latches value_in and blink_mask_in.
- lz_en, input, 1: leading-zero suppression enable; live, sampled every cycle.
- enable, input, 1: 0 blanks all digits; live, sampled every cycle.
- segments_out, output, 7*NUM_DIGITS: segments of digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}.
- blink_phase, output, 1: 1 while blinking digits are in their off half-period.

Behaviour:
- Reset (any cycle reset=1):
  - shadow value = 0; shadow mask = 0; blink counter = 0; blink_phase = 0.
  - segments_out = all digits blank.
  - load is ignored while reset=1.
- Latch: load=1 in cycle t loads the shadow registers at edge t+1.
  - Back-to-back loads: the last one wins.
  - load is sampled only as a level each cycle; no edge detect.
- Output register: segments_out is registered from the shadow registers and the live inputs (lz_en, enable, blink_phase).
  - Latency from load to visible segments is 2 cycles.
  - Latency from a lz_en or enable change is 1 cycle.
- Decode table (ACTIVE_LOW=1):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Blank priority, highest first: enable=0, then blink-off, then leading-zero suppression. A blanked digit outputs the blank code.
- Leading-zero suppression (lz_en=1):
  - Scan from digit NUM_DIGITS-1 downward; blank each zero nibble until the first non-zero nibble.
  - Digit 0 is never suppressed, so a value of 0 shows a single "0".
  - Interior zeros are never suppressed.
- Blink divider:
  - Counter runs 0..BLINK_DIV-1. On the cycle it equals BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - With BLINK_DIV=1, blink_phase toggles every cycle.
  - A digit with shadow mask bit 1 is blanked while blink_phase=1.
- The blink divider is free-running and independent of load; loading does not restart the phase.
- Simultaneous load and counter wrap: both take effect at the same edge, with no interaction.
- Reset asserted mid-operation: all state returns to reset values at the next edge. The first non-blank output appears 1 cycle after reset deasserts. It shows shadow=0, i.e. all digits "0" if lz_en=0, else digit 0 only.
- ACTIVE_LOW=0: every bit of segments_out is the inverse of the ACTIVE_LOW=1 result, including blank codes.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1 unless noted):
1. Reset and decode:
   - Stimulus: reset 3 cycles, release with lz_en=0, enable=1.
   - Response: segments_out all 7'h7F during reset, then 4x 7'b1000000 one cycle later.
2. Load latency:
   - Stimulus: load=1 with value_in=16'h12AF, mask=0 at cycle t.
   - Response: segments_out unchanged at t+1. At t+2 digits 3..0 = 1111001, 0100100, 0001000, 0001110.
3. Leading-zero suppression:
   - Stimulus: load 16'h0040, then 16'h0000, with lz_en=1.
   - Response: 16'h0040 gives digits 3,2 blank, digit1=0011001, digit0=1000000.
   - Response: 16'h0000 gives only digit 0 = 1000000.
   - Response: then toggling lz_en=0 shows all zeros 1 cycle later.
4. Blink:
   - Stimulus: load 16'h8888 with mask=4'b0101.
   - Response: blink_phase toggles every 4 cycles.
   - Response: digits 0 and 2 alternate between 0000000 and 7F in step with blink_phase, delayed 1 cycle; digits 1 and 3 stay 0000000.
5. Priority and reset mid-blink:
   - Stimulus: enable=0 during the blink-on phase.
   - Response: all digits 7F next cycle.
   - Stimulus: then assert reset while blink_phase=1.
   - Response: blink_phase=0, counter=0, mask cleared after release.
6. Polarity and wrap:
   - Stimulus: ACTIVE_LOW=0, BLINK_DIV=1, load 16'h0007 with mask=4'b0001.
   - Response: digit0 alternates 0000111 and 0000000 every cycle; blank digits output 7'h00.
